// File: rtl/cv_line_buffer.sv
// Double-buffered 1 bpp scanline store feeding the composite-video resistor DAC.
// Optional macro CV_LINE_BUFFER_UNDERRUN_PATTERN_EN shows a checkerboard on lines that follow an underrun.
module cv_line_buffer #(
  parameter int PIXELS_PER_LINE = 256,
  parameter int PIXEL_DIV       = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_en,
  input  logic hsync,
  input  logic vsync,
  input  logic hblank,
  input  logic vblank,
  input  logic wr_valid,
  input  logic wr_data,
  output logic wr_ready,
  output logic output_450ohm,
  output logic output_900ohm,
  output logic line_swap,
  output logic underrun
);

  localparam int CNT_W = $clog2(PIXELS_PER_LINE + 1);
  localparam int IDX_W = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
  localparam int SUB_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] LINE_END = CNT_W'(PIXELS_PER_LINE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PIXEL_DIV - 1);

  logic [PIXELS_PER_LINE-1:0] buf0;
  logic [PIXELS_PER_LINE-1:0] buf1;

  logic             front_sel;
  logic             back_full;
  logic             prev_hblank;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] pix_idx;
  logic [SUB_W-1:0] sub;

  logic             swap_pt;
  logic             hblank_fall;
  logic             wr_fire;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             front_bit;
  logic             pix_bit;
  logic [1:0]       dac_next;

  assign swap_pt     = hblank & ~prev_hblank & ~vblank;
  assign hblank_fall = ~hblank & prev_hblank;
  assign wr_ready    = ~back_full;
  assign wr_fire     = wr_valid & ~back_full;
  assign wr_idx      = wr_count[IDX_W-1:0];
  assign rd_idx      = pix_idx[IDX_W-1:0];

  // Line storage is deliberately left unreset; a discarded partial line is simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (front_sel) begin
        buf0[wr_idx] <= wr_data;
      end else begin
        buf1[wr_idx] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_hblank <= 1'b0;
      front_sel   <= 1'b0;
      wr_count    <= '0;
      back_full   <= 1'b0;
      line_swap   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      prev_hblank <= hblank;
      line_swap   <= 1'b0;
      underrun    <= 1'b0;
      if (swap_pt && back_full) begin
        front_sel <= ~front_sel;
        wr_count  <= '0;
        back_full <= 1'b0;
        line_swap <= 1'b1;
      end else begin
        // A write landing on the swap cycle still counts; the line swaps at the next edge.
        if (swap_pt) begin
          underrun <= 1'b1;
        end
        if (wr_fire) begin
          wr_count <= wr_count + 1'b1;
          if (wr_count == LAST_IDX) begin
            back_full <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_idx <= '0;
      sub     <= '0;
    end else if (hblank_fall) begin
      pix_idx <= '0;
      sub     <= '0;
    end else if (clk_en && !hblank && !vblank) begin
      if (sub == SUB_LAST) begin
        sub <= '0;
        if (pix_idx != LINE_END) begin
          pix_idx <= pix_idx + 1'b1;
        end
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

  always_comb begin
    front_bit = 1'b0;
    if (front_sel) begin
      front_bit = buf1[rd_idx];
    end else begin
      front_bit = buf0[rd_idx];
    end
  end

`ifdef CV_LINE_BUFFER_UNDERRUN_PATTERN_EN
  logic pattern_on;
  logic line_parity;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_on  <= 1'b0;
      line_parity <= 1'b0;
    end else if (swap_pt) begin
      line_parity <= ~line_parity;
      pattern_on  <= ~back_full;
    end
  end

  assign pix_bit = pattern_on ? (pix_idx[3] ^ line_parity) : front_bit;
`else
  assign pix_bit = front_bit;
`endif

  // Code 01 is never produced: active video always carries the 900 ohm leg.
  always_comb begin
    dac_next = 2'b10;
    if (hblank || vblank) begin
      dac_next = (hsync || vsync) ? 2'b00 : 2'b10;
    end else if (pix_idx < LINE_END) begin
      dac_next = {1'b1, pix_bit};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      output_900ohm <= 1'b0;
      output_450ohm <= 1'b0;
    end else begin
      output_900ohm <= dac_next[1];
      output_450ohm <= dac_next[0];
    end
  end

endmodule

// File: tb/tb_cv_line_buffer.sv
// Bench for cv_line_buffer: blanking-level table, directed line sequences and random lines
// checked cycle by cycle against a queue-based line model.
module tb_cv_line_buffer;

  localparam int P   = 256;
  localparam int DIV = 10;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic clk_en   = 1'b0;
  logic hsync    = 1'b0;
  logic vsync    = 1'b0;
  logic hblank   = 1'b0;
  logic vblank   = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_data  = 1'b0;
  logic wr_ready;
  logic output_450ohm;
  logic output_900ohm;
  logic line_swap;
  logic underrun;

  cv_line_buffer #(.PIXELS_PER_LINE(P), .PIXEL_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .output_450ohm(output_450ohm), .output_900ohm(output_900ohm),
    .line_swap(line_swap), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: displayed line, pending line as a queue, and a tick count since line start.
  bit front_m [P];
  bit front_known = 1'b0;
  bit backq [$];
  bit src_q [$];
  bit m_prev_hb = 1'b0;
  int ticks = 0;
  bit pat_m = 1'b0;
  bit parity_m = 1'b0;
  bit last_acc = 1'b0;
  int dut_acc = 0;
  int valid_pct = 100;

  typedef struct {
    bit hb;
    bit hs;
    bit vb;
    bit vs;
    logic [1:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit full_pre, sp, e_swap, e_under, chk450, e450;
    logic [1:0] ep;
    int pix;
    full_pre = (backq.size() == P);
    sp       = hblank && !m_prev_hb && !vblank;
    e_swap   = sp && full_pre;
    e_under  = sp && !full_pre;
    pix      = ticks / DIV;
    if (pix > P) pix = P;
    chk450 = 1'b1;
    e450   = 1'b0;
    if (hblank || vblank) begin
      ep = (hsync || vsync) ? 2'b00 : 2'b10;
    end else if (pix >= P) begin
      ep = 2'b10;
    end else begin
`ifdef CV_LINE_BUFFER_UNDERRUN_PATTERN_EN
      if (pat_m) begin
        e450 = pix[3] ^ parity_m;
      end else begin
        e450   = front_m[pix];
        chk450 = front_known;
      end
`else
      e450   = front_m[pix];
      chk450 = front_known;
`endif
      ep = {1'b1, e450};
    end
    if (wr_valid && wr_ready) dut_acc++;
    last_acc = wr_valid && !full_pre;
    @(posedge clk);
    if (sp) begin
      parity_m = !parity_m;
      if (full_pre) begin
        for (int i = 0; i < P; i++) front_m[i] = backq[i];
        front_known = 1'b1;
        backq.delete();
        pat_m = 1'b0;
      end else begin
        pat_m = 1'b1;
      end
    end
    if (last_acc) backq.push_back(wr_data);
    if (!hblank && m_prev_hb) ticks = 0;
    else if (clk_en && !hblank && !vblank && ticks < P * DIV) ticks++;
    m_prev_hb = hblank;
    #1;
    check("line_swap", line_swap, e_swap);
    check("underrun", underrun, e_under);
    check("dac_900", output_900ohm, ep[1]);
    if (chk450) check("dac_450", output_450ohm, ep[0]);
    check("wr_ready", wr_ready, backq.size() != P);
  endtask

  task automatic cycle();
    if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      wr_valid = 1'b1;
      wr_data  = src_q[0];
    end else begin
      wr_valid = 1'b0;
      wr_data  = 1'($urandom_range(1));
    end
    step();
    if (last_acc) void'(src_q.pop_front());
  endtask

  task automatic active(input int n, input int en_pct);
    hblank = 1'b0;
    hsync  = 1'b0;
    for (int i = 0; i < n; i++) begin
      clk_en = ($urandom_range(99) < en_pct);
      cycle();
    end
  endtask

  task automatic blank(input int n);
    hblank = 1'b1;
    for (int i = 0; i < n; i++) begin
      hsync  = (i >= n / 3) && (i < 2 * n / 3);
      clk_en = 1'($urandom_range(1));
      cycle();
    end
    hsync = 1'b0;
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(1'($urandom_range(1)));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    backq.delete();
    front_known = 1'b0;
    ticks       = 0;
    m_prev_hb   = 1'b0;
    pat_m       = 1'b0;
    parity_m    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hblank   = (i % 2) == 0;
      hsync    = (i / 2) == 0;
      vblank   = (i == 3);
      wr_valid = 1'b1;
      clk_en   = 1'b1;
      @(negedge clk);
      check("rst_pins", {output_900ohm, output_450ohm}, 2'b00);
      check("rst_swap", line_swap, 1'b0);
      check("rst_underrun", underrun, 1'b0);
    end
    hblank = 1'b0; hsync = 1'b0; vblank = 1'b0; vsync = 1'b0;
    wr_valid = 1'b0; clk_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_ready", wr_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00};

    do_reset();

    // Blanking and sync levels
    clk_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hblank = vt[i].hb; hsync = vt[i].hs; vblank = vt[i].vb; vsync = vt[i].vs;
      cycle();
      check($sformatf("blank_vec%0d", i), {output_900ohm, output_450ohm}, vt[i].exp);
    end
    hblank = 1'b0; hsync = 1'b0; vblank = 1'b0; vsync = 1'b0;

    // Fill with alternating 1/0, swap, then display while backpressure is exercised
    for (int i = 0; i < P; i++) src_q.push_back((i % 2) == 0);
    valid_pct = 100;
    active(P + 4, 0);
    check("fill_full", wr_ready, 1'b0);
    hblank = 1'b1;
    cycle();
    check("fill_swap", line_swap, 1'b1);
    blank(20);
    check("fill_swap_once", line_swap, 1'b0);
    push_random(300);
    dut_acc = 0;
    active(P * DIV + 30, 100);
    check("bp_accepted", dut_acc, P);
    check("bp_ready_low", wr_ready, 1'b0);
    check("past_end", {output_900ohm, output_450ohm}, 2'b10);
    src_q.delete();
    hblank = 1'b1;
    cycle();
    check("bp_swap", line_swap, 1'b1);
    check("bp_ready_after", wr_ready, 1'b1);
    blank(20);

    // Underrun: only 100 pixels before the swap point
    push_random(100);
    active(P * DIV + 30, 100);
    hblank = 1'b1;
    cycle();
    check("ur_pulse", underrun, 1'b1);
    check("ur_no_swap", line_swap, 1'b0);
    blank(20);
    push_random(P - 100);
    active(P * DIV + 30, 100);
    hblank = 1'b1;
    cycle();
    check("ur_recover_swap", line_swap, 1'b1);
    blank(10);

    // Vertical blanking suppresses the swap point even with a full back buffer
    push_random(P);
    active(P + 10, 0);
    vblank = 1'b1; vsync = 1'b1;
    blank(5);
    vsync = 1'b0;
    active(5, 100);
    hblank = 1'b1;
    cycle();
    check("vb_no_swap", line_swap, 1'b0);
    check("vb_no_underrun", underrun, 1'b0);
    blank(5);
    vblank = 1'b0;
    active(5, 100);
    hblank = 1'b1;
    cycle();
    check("vb_swap_after", line_swap, 1'b1);
    blank(10);

    // Final write on the same clock as the swap point
    push_random(P - 1);
    active(P + 20, 100);
    src_q.push_back(1'b1);
    hblank = 1'b1;
    cycle();
    check("col_underrun", underrun, 1'b1);
    check("col_no_swap", line_swap, 1'b0);
    check("col_full", wr_ready, 1'b0);
    blank(10);
    active(20, 100);
    hblank = 1'b1;
    cycle();
    check("col_swap", line_swap, 1'b1);
    blank(10);
    active(P * DIV + 30, 100);

    // Reset in the middle of a fill discards the partial line
    push_random(50);
    active(60, 100);
    do_reset();
    check("mid_rst_ready", wr_ready, 1'b1);
    src_q.delete();
    push_random(P);
    active(P + 10, 50);
    hblank = 1'b1;
    cycle();
    check("mid_rst_swap", line_swap, 1'b1);
    blank(10);
    active(P * DIV + 30, 100);

    // Random lines
    for (int ln = 0; ln < 8; ln++) begin
      valid_pct = $urandom_range(30, 100);
      push_random($urandom_range(150, 300));
      vblank = (ln == 5);
      blank($urandom_range(5, 40));
      active($urandom_range(200, P * DIV + 50), $urandom_range(40, 100));
      vblank = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv_line_buffer.md
# cv_line_buffer

Double-buffered one-bit-per-pixel line store that sits between the pixel source and the composite-video resistor DAC pins. It accepts the next scanline over a valid/ready stream while the current line plays out. It swaps buffers at the end of each active line. It merges pixel data with the sync and blanking strobes from the timing counter to drive the 450 Ω / 900 Ω outputs.

## Interface
Parameters:
- PIXELS_PER_LINE, 256, active pixels per scanline; also the depth of each buffer half.
- PIXEL_DIV, 10, clk_en ticks per displayed pixel; legal range ≥1.

Ports:
- clk  in  1  system clock (PLL output); one clock only.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  timing tick, shared with the timing counter.
- hsync, vsync, hblank, vblank  in  1 each  strobes from the timing counter.
- wr_valid  in  1  pixel-source data valid.
- wr_data  in  1  pixel value: 1 = white, 0 = black.
- wr_ready  out  1  back buffer accepting data.
- output_450ohm  out  1  DAC LSB.
- output_900ohm  out  1  DAC MSB.
- line_swap  out  1  one-cycle pulse when the buffers swap.
- underrun  out  1  one-cycle pulse when a swap point finds the back buffer not full.

## Operation
- Storage is two PIXELS_PER_LINE × 1 register arrays. front_sel selects the read half; the other half is the back (write) half.
- Write side:
  - wr_count has width $clog2(PIXELS_PER_LINE+1).
  - wr_ready = !back_full.
  - On a wr_valid && wr_ready cycle: back[wr_count] <= wr_data; wr_count++.
  - back_full is set when a write lands at index PIXELS_PER_LINE-1.
- Swap point: the rising edge of hblank, detected against a registered copy of hblank on every clk, while vblank=0.
  - If back_full is set (registered value): toggle front_sel, clear wr_count and back_full, pulse line_swap.
  - If back_full is clear: pulse underrun. front_sel is unchanged, so the front line repeats, and writing continues undisturbed.
  - Swap points are ignored while vblank=1.
- Read side:
  - On the hblank falling edge: pix_idx <= 0 and sub <= 0.
  - On each clk_en with hblank=0 and vblank=0: sub++. When sub==PIXEL_DIV-1, sub <= 0 and pix_idx++, saturating at PIXELS_PER_LINE.
- Output encoding, registered every clk as {output_900ohm, output_450ohm}:
  - hblank||vblank, with hsync||vsync: 00 (sync).
  - hblank||vblank, no sync: 10 (black).
  - Active, pix_idx < PIXELS_PER_LINE: {1, front[pix_idx]}.
  - Active, pix_idx == PIXELS_PER_LINE (past end of line): 10.
  - Code 01 is never driven.

## Timing
- Reset state:
  - Outputs output_450ohm=0, output_900ohm=0, line_swap=0, underrun=0.
  - wr_ready=1 one clk after reset_n deassertion.
  - Internal state front_sel=0, wr_count=0, back_full=0, pix_idx=0, sub=0, prev_hblank=0. Array contents are not reset.
- Reset asserted mid-line or mid-fill aborts immediately. The partial back line is discarded.
- Output latency: one clk from the strobe/pix_idx change to the pins.
- The write handshake is single-cycle. wr_ready deasserts in the cycle after the final write.
- A final write coinciding with a swap point gives underrun. That line swaps at the next swap point.
- line_swap and underrun are mutually exclusive. Each fires at most once per hblank edge.
- After a swap, wr_ready is 1 on the following clk.

## Configuration
- CV_LINE_BUFFER_UNDERRUN_PATTERN_EN
  - Defined: an underrun latches a flag that holds for the following active line. During that line, the active pixel value is pix_idx[3] ^ line_parity (a 16-pixel checkerboard) instead of front data. line_parity is a register that toggles on every swap point outside vblank. The flag clears at the next successful swap.
  - Undefined: an underrun repeats the previous front line; no checkerboard logic is built.

## Test plan
- Reset: hold reset_n=0 with strobes toggling → pins 00, pulses 0. Release → wr_ready=1 next clk.
- Fill and display: write 256 pixels alternating 1/0. Give an hblank rising edge → line_swap=1 for one clk. Next active line with PIXEL_DIV=10 → output_450ohm toggles every 10 clk_en ticks, output_900ohm=1. After pixel 255 → 10.
- Backpressure: keep wr_valid=1 → exactly 256 writes accepted, wr_ready=0 until the swap, then 1 one clk after.
- Underrun: write only 100 pixels before the hblank edge → underrun=1 for one clk, previous line repeats; with the macro defined, checkerboard shows instead.
- Blanking levels: hblank=1, hsync=1 → 00; hblank=1, hsync=0 → 10; vblank=1 with an hblank edge and a full back buffer → no line_swap.
- Edge collision: the 256th write lands in the same clk as the hblank rising edge → underrun pulse. Next hblank edge → line_swap with the written data displayed.
